// File: rtl/pcap_frame_sequencer.sv
// pcap_frame_sequencer
//
// Takes bytes from a first-word fall-through FIFO holding a raw pcap capture
// file and passes them to the UDP parser FIFO. The 24-byte global header is
// skipped once after reset. Each 16-byte record header is consumed and its
// incl_len field captured. Records of 1..MAX_FRAME_BYTES bytes are forwarded
// with sof/eof framing. Zero-length and oversized records are dropped.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   din, empty, rd_en     input FIFO head byte, empty flag, pop strobe
//   dout, wr_en, full     parser FIFO byte, push strobe, full flag
//   out_sof, out_eof      first / last byte of a forwarded frame
//   frame_count           frames forwarded (wraps)
//   drop_count            records dropped (wraps)
//   busy                  inside a record (partial header, payload or drop)
//
// state      | meaning
// GLOBAL_HDR | skipping the global file header
// REC_HDR    | reading a record header, capturing incl_len
// PAYLOAD    | forwarding incl_len frame bytes to the parser
// DROP       | discarding incl_len bytes of an oversized record

module pcap_frame_sequencer #(
    parameter int unsigned PCAP_HEADER_BYTES      = 24,
    parameter int unsigned PCAP_DATA_HEADER_BYTES = 16,
    parameter int unsigned INCL_LEN_OFFSET        = 8,
    parameter int unsigned MAX_FRAME_BYTES        = 1518,
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned COUNT_WIDTH            = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   empty,
    output logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   wr_en,
    output logic                   out_sof,
    output logic                   out_eof,
    input  logic                   full,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        GLOBAL_HDR,
        REC_HDR,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic [31:0] GH_LAST = 32'(PCAP_HEADER_BYTES - 1);
    localparam logic [31:0] RH_LAST = 32'(PCAP_DATA_HEADER_BYTES - 1);
    localparam logic [31:0] LEN_LO  = 32'(INCL_LEN_OFFSET);
    localparam logic [31:0] LEN_HI  = 32'(INCL_LEN_OFFSET + 3);
    localparam logic [31:0] MAX_LEN = 32'(MAX_FRAME_BYTES);
    localparam logic [1:0]  OFF_LSB = 2'(INCL_LEN_OFFSET % 4);

    state_t      state;
    logic [31:0] byte_cnt;
    logic [31:0] incl_len;
    logic [31:0] incl_len_next;
    logic [1:0]  len_sel;
    logic        last_len;

    // incl_len including the byte currently at the FIFO head, so the decision
    // on the final header byte sees the complete field wherever it sits.
    always_comb begin
        incl_len_next = incl_len;
        len_sel       = byte_cnt[1:0] - OFF_LSB;
        if (state == REC_HDR && byte_cnt >= LEN_LO && byte_cnt <= LEN_HI)
            incl_len_next[{len_sel, 3'b000} +: 8] = din[7:0];
    end

    assign last_len = (byte_cnt == incl_len - 32'd1);

    // Handshake is combinational so a byte moves from FIFO head to parser in
    // the same cycle. Everything is forced low while reset is held.
    always_comb begin
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        out_sof = 1'b0;
        out_eof = 1'b0;
        if (!reset) begin
            case (state)
                PAYLOAD: begin
                    rd_en   = !empty && !full;
                    wr_en   = rd_en;
                    out_sof = rd_en && (byte_cnt == 32'd0);
                    out_eof = rd_en && last_len;
                end
                default: rd_en = !empty;
            endcase
        end
    end

    assign dout = reset ? '0 : din;
    assign busy = !reset && ((state == REC_HDR && byte_cnt != 32'd0) ||
                             state == PAYLOAD || state == DROP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= GLOBAL_HDR;
            byte_cnt    <= '0;
            incl_len    <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else if (rd_en) begin
            case (state)
                GLOBAL_HDR: begin
                    if (byte_cnt == GH_LAST) begin
                        byte_cnt <= '0;
                        state    <= REC_HDR;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                    end
                end
                REC_HDR: begin
                    incl_len <= incl_len_next;
                    if (byte_cnt == RH_LAST) begin
                        byte_cnt <= '0;
                        if (incl_len_next == 32'd0)
                            drop_count <= drop_count + 1'b1;
                        else if (incl_len_next > MAX_LEN)
                            state <= DROP;
                        else
                            state <= PAYLOAD;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                    end
                end
                PAYLOAD: begin
                    if (last_len) begin
                        byte_cnt    <= '0;
                        frame_count <= frame_count + 1'b1;
                        state       <= REC_HDR;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                    end
                end
                DROP: begin
                    if (last_len) begin
                        byte_cnt   <= '0;
                        drop_count <= drop_count + 1'b1;
                        state      <= REC_HDR;
                    end else begin
                        byte_cnt <= byte_cnt + 32'd1;
                    end
                end
                default: state <= GLOBAL_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_pcap_frame_sequencer.sv
// Bench for pcap_frame_sequencer: record-level vector table plus hand-written
// back-pressure and mid-record reset sequences. A scoreboard holds every byte
// that should reach the parser, with its expected sof/eof flags.

module tb_pcap_frame_sequencer;

    logic        clock;
    logic        reset;
    logic [7:0]  din;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout;
    logic        wr_en;
    logic        out_sof;
    logic        out_eof;
    logic        full;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        busy;

    pcap_frame_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .empty       (empty),
        .rd_en       (rd_en),
        .dout        (dout),
        .wr_en       (wr_en),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .full        (full),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } push_t;

    typedef struct {
        int n;          // records in this vector
        int l0;
        int l1;
        int l2;
        int empty_pct;
        int pushes;     // expected parser pushes
        int frames;     // expected frame_count
        int drops;      // expected drop_count
    } vec_t;

    logic [7:0] src_q[$];
    push_t      exp_q[$];
    int         nvec = 0;
    int         nfail = 0;
    int         push_cnt = 0;
    int         sof_cnt = 0;
    int         eof_cnt = 0;
    int         empty_pct = 0;
    bit         full_force = 1'b0;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe just before
    // the next one (the outputs seen there are what the edge will act on).
    task automatic cycle();
        push_t e;
        @(posedge clock);
        #1;
        empty = (src_q.size() == 0) ||
                (empty_pct > 0 && $urandom_range(0, 99) < empty_pct);
        din   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        full  = full_force;
        #3;
        check("no_push_when_full", {31'd0, wr_en & full}, 32'd0);
        check("no_pop_when_empty", {31'd0, rd_en & empty}, 32'd0);
        check("dout_follows_din", {24'd0, dout}, {24'd0, din});
        if (rd_en && src_q.size() > 0) void'(src_q.pop_front());
        if (wr_en) begin
            push_cnt++;
            if (out_sof) sof_cnt++;
            if (out_eof) eof_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("push_data", {24'd0, dout}, {24'd0, e.data});
                check("push_sof", {31'd0, out_sof}, {31'd0, e.sof});
                check("push_eof", {31'd0, out_eof}, {31'd0, e.eof});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        empty      = 1'b0;
        din        = 8'h5A;
        full       = 1'b0;
        full_force = 1'b0;
        empty_pct  = 0;
        src_q.delete();
        exp_q.delete();
        #3;
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_sof_eof", {30'd0, out_sof, out_eof}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #4;
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_busy_held", {31'd0, busy}, 32'd0);
        reset    = 1'b0;
        empty    = 1'b1;
        push_cnt = 0;
        sof_cnt  = 0;
        eof_cnt  = 0;
    endtask

    task automatic add_global();
        for (int i = 0; i < 24; i++) src_q.push_back(8'(i * 7 + 3));
    endtask

    task automatic add_record(input int len);
        logic [31:0] lenv;
        logic [7:0]  b;
        bit          fwd;
        lenv = 32'(len);
        fwd  = (len >= 1) && (len <= 1518);
        for (int i = 0; i < 8; i++) src_q.push_back(8'(32'hE0 + i));
        for (int k = 0; k < 4; k++) src_q.push_back(lenv[8*k +: 8]);
        for (int k = 0; k < 4; k++) src_q.push_back(lenv[8*k +: 8]);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            src_q.push_back(b);
            if (fwd) exp_q.push_back('{data: b, sof: (i == 0), eof: (i == len - 1)});
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (src_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (src_q.size() > 0) check("drain_timeout", 32'(src_q.size()), 32'd0);
        repeat (2) cycle();
    endtask

    task automatic run_until_pushes(input int target, input int budget);
        int n = 0;
        while (push_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        if (push_cnt < target) check("push_wait_timeout", 32'(push_cnt), 32'(target));
    endtask

    initial begin
        reset = 1'b1;
        empty = 1'b1;
        din   = 8'h00;
        full  = 1'b0;

        vecs[0] = '{n: 1, l0: 60,   l1: 0,    l2: 0,    empty_pct: 0,  pushes: 60,   frames: 1, drops: 0};
        vecs[1] = '{n: 2, l0: 2000, l1: 64,   l2: 0,    empty_pct: 0,  pushes: 64,   frames: 1, drops: 1};
        vecs[2] = '{n: 2, l0: 0,    l1: 1,    l2: 0,    empty_pct: 0,  pushes: 1,    frames: 1, drops: 1};
        vecs[3] = '{n: 3, l0: 42,   l1: 64,   l2: 1518, empty_pct: 50, pushes: 1624, frames: 3, drops: 0};
        vecs[4] = '{n: 2, l0: 1519, l1: 1518, l2: 0,    empty_pct: 0,  pushes: 1518, frames: 1, drops: 1};
        vecs[5] = '{n: 3, l0: 1,    l1: 2,    l2: 0,    empty_pct: 30, pushes: 3,    frames: 2, drops: 1};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            add_global();
            add_record(vecs[v].l0);
            if (vecs[v].n > 1) add_record(vecs[v].l1);
            if (vecs[v].n > 2) add_record(vecs[v].l2);
            empty_pct = vecs[v].empty_pct;
            drain(20000);
            check($sformatf("v%0d_pushes", v), 32'(push_cnt), 32'(vecs[v].pushes));
            check($sformatf("v%0d_sof", v), 32'(sof_cnt), 32'(vecs[v].frames));
            check($sformatf("v%0d_eof", v), 32'(eof_cnt), 32'(vecs[v].frames));
            check($sformatf("v%0d_frame_count", v), {16'd0, frame_count}, 32'(vecs[v].frames));
            check($sformatf("v%0d_drop_count", v), {16'd0, drop_count}, 32'(vecs[v].drops));
            check($sformatf("v%0d_missing", v), 32'(exp_q.size()), 32'd0);
            check($sformatf("v%0d_idle_busy", v), {31'd0, busy}, 32'd0);
        end

        // Parser FIFO full for 5 cycles once bytes 0..19 have been pushed.
        do_reset();
        add_global();
        add_record(60);
        run_until_pushes(20, 500);
        full_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_rd_en", {31'd0, rd_en}, 32'd0);
            check("bp_wr_en", {31'd0, wr_en}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        check("bp_hold_count", 32'(push_cnt), 32'd20);
        full_force = 1'b0;
        drain(2000);
        check("bp_pushes", 32'(push_cnt), 32'd60);
        check("bp_frame_count", {16'd0, frame_count}, 32'd1);
        check("bp_missing", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the second frame (payload byte 30).
        do_reset();
        add_global();
        add_record(60);
        add_record(60);
        run_until_pushes(90, 2000);
        check("mid_pre_frame_count", {16'd0, frame_count}, 32'd1);
        check("mid_pre_busy", {31'd0, busy}, 32'd1);
        do_reset();
        add_global();
        add_record(60);
        drain(2000);
        check("mid_post_pushes", 32'(push_cnt), 32'd60);
        check("mid_post_sof", 32'(sof_cnt), 32'd1);
        check("mid_post_eof", 32'(eof_cnt), 32'd1);
        check("mid_post_frame_count", {16'd0, frame_count}, 32'd1);
        check("mid_post_drop_count", {16'd0, drop_count}, 32'd0);
        check("mid_post_missing", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
